// File: rtl/ibex_instr_realigner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ibex_instr_realigner_pkg
// Purpose : Helpers shared by the fetch realigner and the compressed
//           instruction decoder.
// Contents: is_compressed_f - a 16-bit parcel starts a compressed (RVC)
//           instruction unless its two lowest bits are 2'b11.
// Revision: 1.0 - initial release
// ============================================================================
package ibex_instr_realigner_pkg;

  function automatic logic is_compressed_f(logic [15:0] instr);
    return (instr[1:0] != 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_instr_realigner_if.sv
`default_nettype none
// ============================================================================
// Module  : ibex_instr_realigner_if
// Purpose : Bundles the fetch-response side, the decoder side and the flush
//           request of the instruction realigner.
// Modports: master - environment (memory response path, IF-ID, flush source)
//           slave  - the realigner itself
// Signals : clear_i/clear_addr_i  flush and restart PC
//           in_*                  word-aligned fetch responses
//           out_*                 realigned instruction towards IF-ID
// Revision: 1.0 - initial release
// ============================================================================
interface ibex_instr_realigner_if;
  logic        clear_i;
  logic [31:0] clear_addr_i;

  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_rdata_i;
  logic        in_err_i;

  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_compressed_o;
  logic        out_err_o;
  logic        out_err_plus2_o;

  modport master (
    output clear_i, clear_addr_i,
    output in_valid_i, in_rdata_i, in_err_i,
    input  in_ready_o,
    output out_ready_i,
    input  out_valid_o, out_rdata_o, out_addr_o, out_compressed_o,
    input  out_err_o, out_err_plus2_o
  );

  modport slave (
    input  clear_i, clear_addr_i,
    input  in_valid_i, in_rdata_i, in_err_i,
    output in_ready_o,
    input  out_ready_i,
    output out_valid_o, out_rdata_o, out_addr_o, out_compressed_o,
    output out_err_o, out_err_plus2_o
  );
endinterface
`default_nettype wire

// File: rtl/ibex_instr_realigner.sv
`default_nettype none
// ============================================================================
// Module  : ibex_instr_realigner
// Purpose : Buffers 32-bit word-aligned fetch responses and hands one 16- or
//           32-bit instruction per handshake to the decoder, realigned to
//           bit 0, including instructions straddling a word boundary.
// Ports   : clk_i   - clock
//           rst_ni  - asynchronous active-low reset
//           bus     - slave modport: clear, fetch input, instruction output
// Params  : DEPTH   - buffered words (2..4)
// Revision: 1.0 - initial release
// ============================================================================
module ibex_instr_realigner
  import ibex_instr_realigner_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  ibex_instr_realigner_if.slave     bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      r_mem [DEPTH];
  logic             r_err [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pc;

  // Circular index arithmetic for a non power-of-two depth.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input logic [CNT_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(base) + SUM_W'(inc);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return s[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0] w_idx1;
  logic [IDX_W-1:0] w_wr_idx;
  logic [31:0]      w_head_word;
  logic             w_head_err;
  logic [31:0]      w_e1_word;
  logic             w_e1_err;
  logic             w_offset;
  logic             w_has1;
  logic             w_has2;
  logic [15:0]      w_low;
  logic             w_comp;
  logic             w_valid;
  logic [31:0]      w_instr;
  logic             w_err;
  logic             w_plus2;
  logic             w_push;
  logic             w_fire;
  logic             w_pop;

  assign w_idx1      = wrap_idx(r_head, CNT_W'(1));
  assign w_wr_idx    = wrap_idx(r_head, r_count);
  assign w_head_word = r_mem[r_head];
  assign w_head_err  = r_err[r_head];
  assign w_e1_word   = r_mem[w_idx1];
  assign w_e1_err    = r_err[w_idx1];
  assign w_offset    = r_pc[1];
  assign w_has1      = (r_count != '0);
  assign w_has2      = (r_count >= CNT_W'(2));
  assign w_low       = w_offset ? w_head_word[31:16] : w_head_word[15:0];
  assign w_comp      = is_compressed_f(w_low);

  always_comb begin
    w_valid = 1'b0;
    w_instr = '0;
    w_err   = 1'b0;
    w_plus2 = 1'b0;
    if (!w_offset) begin
      w_valid = w_has1;
      w_instr = w_comp ? {16'h0, w_low} : w_head_word;
      w_err   = w_head_err;
    end else if (w_comp) begin
      w_valid = w_has1;
      w_instr = {16'h0, w_low};
      w_err   = w_head_err;
    end else begin
      // A straddling instruction whose first half already errored is
      // released without waiting for the second word. Its upper half is
      // held at zero so the output does not change if that word arrives
      // while the decoder stalls.
      w_valid = w_has2 | (w_has1 & w_head_err);
      w_instr = {(w_has2 & ~w_head_err) ? w_e1_word[15:0] : 16'h0, w_low};
      w_err   = w_head_err | (w_has2 & w_e1_err);
      w_plus2 = ~w_head_err & w_has2 & w_e1_err;
    end
  end

  assign bus.in_ready_o       = (r_count < CNT_W'(DEPTH));
  assign bus.out_valid_o      = w_valid;
  assign bus.out_rdata_o      = w_valid ? w_instr : 32'h0;
  assign bus.out_addr_o       = r_pc;
  assign bus.out_compressed_o = w_valid & w_comp;
  assign bus.out_err_o        = w_valid & w_err;
  assign bus.out_err_plus2_o  = w_valid & w_plus2;

  assign w_push = bus.in_valid_i & bus.in_ready_o & ~bus.clear_i;
  assign w_fire = w_valid & bus.out_ready_i & ~bus.clear_i;
  // Only an aligned compressed instruction leaves part of its word unused.
  assign w_pop  = w_fire & (w_offset | ~w_comp);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
        r_err[i] <= 1'b0;
      end
      r_head  <= '0;
      r_count <= '0;
      r_pc    <= '0;
    end else if (bus.clear_i) begin
      r_head  <= '0;
      r_count <= '0;
      r_pc    <= bus.clear_addr_i & ~32'h1;
    end else begin
      if (w_push) begin
        r_mem[w_wr_idx] <= bus.in_rdata_i;
        r_err[w_wr_idx] <= bus.in_err_i;
      end
      if (w_pop) r_head <= w_idx1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_fire) r_pc <= r_pc + (w_comp ? 32'd2 : 32'd4);
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_push |-> (r_count < CNT_W'(DEPTH)));

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.out_valid_o & ~bus.out_ready_i & ~bus.clear_i) |=>
      (bus.out_valid_o && $stable(bus.out_rdata_o) && $stable(bus.out_addr_o) &&
       $stable(bus.out_err_o) && $stable(bus.out_err_plus2_o) &&
       $stable(bus.out_compressed_o)));

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= CNT_W'(DEPTH));
`endif

endmodule
`default_nettype wire
